// File: rtl/amp_power_sequencer.sv
// amp_power_sequencer: amplifier power-up, I2C config handshake, fault recovery and lockout.
module amp_power_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYC     = 1000,
  parameter int unsigned PWR_CYC     = 4000,
  parameter int unsigned IDLE_CYC    = 64,
  parameter int unsigned CFG_TIMEOUT = 60000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_in,
  input  logic       resetb,
  input  logic       enable,
  input  logic       amp_fault_n,
  input  logic       i2c_scl,
  output logic       i2c_resetb,
  output logic       send_cfg,
  output logic       amp_nreset,
  output logic       amp_nmute,
  output logic       ready,
  output logic       fault,
  output logic [2:0] retry_cnt
);

  localparam int unsigned FLT_W   = 3;
  localparam int unsigned FLT_LEN = 4;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FLT_LEN - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE,
    RESET_HOLD,
    POWER_WAIT,
    SEND,
    CFG_WAIT,
    UNMUTE,
    RUN,
    FAULT_HOLD,
    SHUTDOWN,
    LOCKOUT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   idle_cnt;
  logic [1:0]         fault_sync;
  logic [1:0]         scl_sync;
  logic [FLT_W-1:0]   flt_cnt;
  logic               fault_s;
  logic               scl_s;
  logic               fault_det_c;
  logic               idle_done_c;
  logic               pwr_on_c;
  logic               keep_cnt_c;

  assign fault_s = fault_sync[1];
  assign scl_s   = scl_sync[1];

  // Two-flop synchronisers for the asynchronous fault pin and the monitored SCL line.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      fault_sync <= 2'b11;
      scl_sync   <= 2'b11;
    end else begin
      fault_sync <= {fault_sync[0], amp_fault_n};
      scl_sync   <= {scl_sync[0], i2c_scl};
    end
  end

  // Glitch filter: counts consecutive synced-low cycles, saturating one short of the threshold.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      flt_cnt <= '0;
    end else if (fault_s) begin
      flt_cnt <= '0;
    end else if (flt_cnt != FLT_LAST) begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  // Fault is seen on the fourth consecutive low cycle and drops on the first high cycle.
  assign fault_det_c = !fault_s && (flt_cnt == FLT_LAST);

  // Consecutive SCL-high cycles while waiting for the config transfer to finish.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      idle_cnt <= '0;
    end else if ((state != CFG_WAIT) || !scl_s) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_MAX) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  assign idle_done_c = scl_s && (idle_cnt == IDLE_LAST);

  // Next-state selection; shutdown outranks fault, fault outranks timeout and progress.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RESET_HOLD;
      end
      RESET_HOLD: begin
        if (!enable)              state_nxt = SHUTDOWN;
        else if (cnt == RST_LAST) state_nxt = POWER_WAIT;
      end
      POWER_WAIT: begin
        if (!enable)              state_nxt = SHUTDOWN;
        else if (fault_det_c)     state_nxt = FAULT_HOLD;
        else if (cnt == PWR_LAST) state_nxt = SEND;
      end
      SEND: begin
        if (!enable)             state_nxt = SHUTDOWN;
        else if (fault_det_c)    state_nxt = FAULT_HOLD;
        else if (cnt == TO_LAST) state_nxt = FAULT_HOLD;
        else if (!scl_s)         state_nxt = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (!enable)             state_nxt = SHUTDOWN;
        else if (fault_det_c)    state_nxt = FAULT_HOLD;
        else if (cnt == TO_LAST) state_nxt = FAULT_HOLD;
        else if (idle_done_c)    state_nxt = UNMUTE;
      end
      UNMUTE: begin
        if (!enable)          state_nxt = SHUTDOWN;
        else if (fault_det_c) state_nxt = FAULT_HOLD;
        else                  state_nxt = RUN;
      end
      RUN: begin
        if (!enable)          state_nxt = SHUTDOWN;
        else if (fault_det_c) state_nxt = FAULT_HOLD;
      end
      FAULT_HOLD: begin
        if (!enable)                    state_nxt = SHUTDOWN;
        else if (retry_cnt < RETRY_MAX) state_nxt = RESET_HOLD;
        else                            state_nxt = LOCKOUT;
      end
      SHUTDOWN: begin
        state_nxt = IDLE;
      end
      LOCKOUT: begin
        if (!enable) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Amp and master are powered out of reset from POWER_WAIT through RUN.
  assign pwr_on_c = (state_nxt == POWER_WAIT) || (state_nxt == SEND) ||
                    (state_nxt == CFG_WAIT)   || (state_nxt == UNMUTE) ||
                    (state_nxt == RUN);

  // The config timeout spans SEND and CFG_WAIT, so that move keeps the count running.
  assign keep_cnt_c = (state_nxt == state) || ((state == SEND) && (state_nxt == CFG_WAIT));

  // State, shared delay counter and all pin outputs, registered from the next state.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      cnt        <= '0;
      i2c_resetb <= 1'b0;
      send_cfg   <= 1'b0;
      amp_nreset <= 1'b0;
      amp_nmute  <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (!keep_cnt_c) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Shutdown mutes first and leaves the reset pins alone for one cycle.
      if (state_nxt != SHUTDOWN) begin
        i2c_resetb <= pwr_on_c;
        amp_nreset <= pwr_on_c;
      end
      send_cfg  <= (state_nxt == SEND);
      amp_nmute <= (state_nxt == UNMUTE) || (state_nxt == RUN);
      ready     <= (state_nxt == RUN);

      if ((state == FAULT_HOLD) && (state_nxt == RESET_HOLD)) begin
        retry_cnt <= retry_cnt + 3'd1;
      end else if ((state_nxt == SHUTDOWN) ||
                   ((state == LOCKOUT) && (state_nxt == IDLE)) ||
                   ((state == RUN) && (state_nxt == RUN) && (cnt == CNT_MAX))) begin
        retry_cnt <= '0;
      end

      if ((state == FAULT_HOLD) && (state_nxt == LOCKOUT)) begin
        fault <= 1'b1;
      end else if ((state == LOCKOUT) && (state_nxt == IDLE)) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_amp_power_sequencer.sv
// tb_amp_power_sequencer: scoreboard bench; expected output transitions queued, monitor checks each change.
module tb_amp_power_sequencer;

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned RST_CYC     = 4;
  localparam int unsigned PWR_CYC     = 8;
  localparam int unsigned IDLE_CYC    = 4;
  localparam int unsigned CFG_TIMEOUT = 200;
  localparam int unsigned MAX_RETRY   = 2;

  logic       clk_in      = 1'b0;
  logic       resetb      = 1'b0;
  logic       enable      = 1'b0;
  logic       amp_fault_n = 1'b1;
  logic       i2c_scl     = 1'b1;
  logic       i2c_resetb;
  logic       send_cfg;
  logic       amp_nreset;
  logic       amp_nmute;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;

  amp_power_sequencer #(
    .CNT_W      (CNT_W),
    .RST_CYC    (RST_CYC),
    .PWR_CYC    (PWR_CYC),
    .IDLE_CYC   (IDLE_CYC),
    .CFG_TIMEOUT(CFG_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk_in     (clk_in),
    .resetb     (resetb),
    .enable     (enable),
    .amp_fault_n(amp_fault_n),
    .i2c_scl    (i2c_scl),
    .i2c_resetb (i2c_resetb),
    .send_cfg   (send_cfg),
    .amp_nreset (amp_nreset),
    .amp_nmute  (amp_nmute),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Edge counter: after posedge k it reads k.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [8:0] vec;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // {i2c_resetb, send_cfg, amp_nreset, amp_nmute, ready, fault, retry_cnt}
  logic [8:0] out_vec;
  logic [8:0] prev_vec = '0;
  assign out_vec = {i2c_resetb, send_cfg, amp_nreset, amp_nmute, ready, fault, retry_cnt};

  function automatic logic [8:0] mk(input logic ir, input logic sc, input logic nr,
                                    input logic nm, input logic rd, input logic fl,
                                    input int rc);
    return {ir, sc, nr, nm, rd, fl, 3'(rc)};
  endfunction

  task automatic push_exp(input string name, input logic [8:0] v, input int at);
    q.push_back('{name, v, at});
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Waits for the scoreboard to empty; an expired budget is a failure.
  task automatic drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(posedge clk_in);
      n++;
    end
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected transitions pending (next %s), required 0",
               tag, q.size(), q[0].name);
      q.delete();
    end
  endtask

  // Config transfer model: SCL low 3 cycles after SEND, 40 toggles, then idle high.
  task automatic run_cfg(input int s);
    goto_cyc(s + 3);
    i2c_scl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1;
      i2c_scl = ~i2c_scl;
    end
    @(posedge clk_in);
    #1;
    i2c_scl = 1'b1;
  endtask

  // Monitor: every output change must match the next queued transition and its edge.
  always @(negedge clk_in) begin
    if (!resetb) begin
      prev_vec = out_vec;
    end else if (out_vec !== prev_vec) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change from %b",
                 out_vec, cyc, prev_vec);
      end else begin
        mon_e = q.pop_front();
        if ((out_vec !== mon_e.vec) || (cyc != mon_e.at)) begin
          fails++;
          $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                   mon_e.name, out_vec, cyc, mon_e.vec, mon_e.at);
        end
      end
      prev_vec = out_vec;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", out_vec, 9'b0);
    resetb = 1'b1;
    goto_cyc(cyc + 2);

    // Bring-up.
    t = cyc;
    enable = 1'b1;
    push_exp("bring_pwr",     mk(1, 0, 1, 0, 0, 0, 0), t + 5);
    push_exp("bring_send",    mk(1, 1, 1, 0, 0, 0, 0), t + 13);
    push_exp("bring_cfgwait", mk(1, 0, 1, 0, 0, 0, 0), t + 19);
    push_exp("bring_unmute",  mk(1, 0, 1, 1, 0, 0, 0), t + 63);
    push_exp("bring_run",     mk(1, 0, 1, 1, 1, 0, 0), t + 64);
    run_cfg(t + 13);
    drain(100, "bringup");

    // Three-cycle fault glitch is filtered out.
    t = cyc;
    amp_fault_n = 1'b0;
    goto_cyc(t + 3);
    amp_fault_n = 1'b1;
    goto_cyc(t + 15);
    check("short_pulse_ignored", out_vec, mk(1, 0, 1, 1, 1, 0, 0));

    // Six-cycle fault: recovery sequence, then retry count clears after a long RUN.
    t = cyc;
    amp_fault_n = 1'b0;
    push_exp("rt_fault_hold",  mk(0, 0, 0, 0, 0, 0, 0), t + 6);
    push_exp("rt_retry",       mk(0, 0, 0, 0, 0, 0, 1), t + 7);
    push_exp("rt_pwr",         mk(1, 0, 1, 0, 0, 0, 1), t + 11);
    push_exp("rt_send",        mk(1, 1, 1, 0, 0, 0, 1), t + 19);
    push_exp("rt_cfgwait",     mk(1, 0, 1, 0, 0, 0, 1), t + 25);
    push_exp("rt_unmute",      mk(1, 0, 1, 1, 0, 0, 1), t + 69);
    push_exp("rt_run",         mk(1, 0, 1, 1, 1, 0, 1), t + 70);
    push_exp("rt_retry_clear", mk(1, 0, 1, 1, 1, 0, 0), t + 70 + 256);
    goto_cyc(t + 6);
    amp_fault_n = 1'b1;
    run_cfg(t + 19);
    drain(400, "runtime_fault");

    // Orderly shutdown from RUN.
    t = cyc;
    enable = 1'b0;
    push_exp("sd_mute", mk(1, 0, 1, 0, 0, 0, 0), t + 1);
    push_exp("sd_idle", mk(0, 0, 0, 0, 0, 0, 0), t + 2);
    drain(20, "shutdown");

    // Config timeout with SCL stuck high, then a successful retry.
    goto_cyc(cyc + 2);
    t = cyc;
    enable = 1'b1;
    push_exp("to_pwr",        mk(1, 0, 1, 0, 0, 0, 0), t + 5);
    push_exp("to_send",       mk(1, 1, 1, 0, 0, 0, 0), t + 13);
    push_exp("to_fault_hold", mk(0, 0, 0, 0, 0, 0, 0), t + 213);
    push_exp("to_retry",      mk(0, 0, 0, 0, 0, 0, 1), t + 214);
    push_exp("to_pwr2",       mk(1, 0, 1, 0, 0, 0, 1), t + 218);
    push_exp("to_send2",      mk(1, 1, 1, 0, 0, 0, 1), t + 226);
    push_exp("to_cfgwait",    mk(1, 0, 1, 0, 0, 0, 1), t + 232);
    push_exp("to_unmute",     mk(1, 0, 1, 1, 0, 0, 1), t + 276);
    push_exp("to_run",        mk(1, 0, 1, 1, 1, 0, 1), t + 277);
    run_cfg(t + 226);
    drain(100, "timeout");

    // Enable low and fault detection in the same cycle: shutdown wins, retries cleared.
    t = cyc;
    amp_fault_n = 1'b0;
    goto_cyc(t + 5);
    enable = 1'b0;
    push_exp("both_sd",   mk(1, 0, 1, 0, 0, 0, 0), t + 6);
    push_exp("both_idle", mk(0, 0, 0, 0, 0, 0, 0), t + 7);
    drain(20, "simultaneous");

    // Persistent fault exhausts retries and locks out.
    t = cyc;
    enable = 1'b1;
    push_exp("lo_pwr0",    mk(1, 0, 1, 0, 0, 0, 0), t + 5);
    push_exp("lo_hold0",   mk(0, 0, 0, 0, 0, 0, 0), t + 6);
    push_exp("lo_rst1",    mk(0, 0, 0, 0, 0, 0, 1), t + 7);
    push_exp("lo_pwr1",    mk(1, 0, 1, 0, 0, 0, 1), t + 11);
    push_exp("lo_hold1",   mk(0, 0, 0, 0, 0, 0, 1), t + 12);
    push_exp("lo_rst2",    mk(0, 0, 0, 0, 0, 0, 2), t + 13);
    push_exp("lo_pwr2",    mk(1, 0, 1, 0, 0, 0, 2), t + 17);
    push_exp("lo_hold2",   mk(0, 0, 0, 0, 0, 0, 2), t + 18);
    push_exp("lo_lockout", mk(0, 0, 0, 0, 0, 1, 2), t + 19);
    drain(60, "lockout");
    amp_fault_n = 1'b1;
    goto_cyc(cyc + 10);

    // One cycle of enable low leaves lockout; a fresh sequence starts.
    t = cyc;
    enable = 1'b0;
    push_exp("lo_exit",    mk(0, 0, 0, 0, 0, 0, 0), t + 1);
    push_exp("re_pwr",     mk(1, 0, 1, 0, 0, 0, 0), t + 6);
    push_exp("re_send",    mk(1, 1, 1, 0, 0, 0, 0), t + 14);
    push_exp("re_cfgwait", mk(1, 0, 1, 0, 0, 0, 0), t + 20);
    goto_cyc(t + 1);
    enable = 1'b1;
    goto_cyc(t + 17);
    i2c_scl = 1'b0;
    drain(20, "relaunch");

    // Asynchronous reset in CFG_WAIT, between clock edges.
    #2;
    resetb = 1'b0;
    #1;
    check("async_reset", out_vec, 9'b0);
    enable  = 1'b0;
    i2c_scl = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    resetb = 1'b1;
    goto_cyc(cyc + 5);
    check("post_reset_idle", out_vec, 9'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
